// File: rtl/rv_mem_pkg.sv
// Shared definitions for the rv_mem request/response protocol.
package rv_mem_pkg;

  typedef enum logic {
    RV_MEM_READ  = 1'b0,
    RV_MEM_WRITE = 1'b1
  } rv_mem_op_e;

endpackage

// File: rtl/rv_mem_intf.sv
// Valid/ready memory channel: op, word address and data travel together.
interface rv_mem_intf
  import rv_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  rv_mem_op_e            op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  modport in  (input  valid, op, addr, data, output ready);
  modport out (output valid, op, addr, data, input  ready);
endinterface

// File: rtl/rv_mem_resp_buffer.sv
// Two-entry circular response FIFO with a 0..2 occupancy count.
// Push is ignored when full and pop when empty; head data is registered storage only.
module rv_mem_resp_buffer #(
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == 2'd2);
  assign empty_o    = (count_q == 2'd0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rv_mem_reg_bank.sv
// Software register bank on an rv_mem request channel; reads answer through a 2-entry buffer.
// Request ready depends only on buffer occupancy, never on the response consumer.
module rv_mem_reg_bank
  import rv_mem_pkg::*;
#(
  parameter int                   NUM_REGS    = 8,
  parameter int                   DATA_WIDTH  = 32,
  parameter int                   ADDR_WIDTH  = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  rv_mem_intf.in                         mem_req,
  rv_mem_intf.out                        mem_resp,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  if (mem_req.DATA_WIDTH != DATA_WIDTH || mem_resp.DATA_WIDTH != DATA_WIDTH) begin : g_dw_chk
    $error("rv_mem_reg_bank: mem_req/mem_resp DATA_WIDTH mismatch");
  end
  if (mem_req.ADDR_WIDTH != ADDR_WIDTH || mem_resp.ADDR_WIDTH != ADDR_WIDTH) begin : g_aw_chk
    $error("rv_mem_reg_bank: mem_req/mem_resp ADDR_WIDTH mismatch");
  end
  if (ADDR_WIDTH < IDXW) begin : g_idx_chk
    $error("rv_mem_reg_bank: ADDR_WIDTH too small for NUM_REGS");
  end

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [IDXW-1:0]       idx;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  accept, in_range, push;
  logic                  buf_full, buf_empty;

  assign idx      = mem_req.addr[IDXW-1:0];
  assign in_range = (32'(mem_req.addr) < 32'(NUM_REGS));
  assign accept   = mem_req.valid && mem_req.ready;
  assign push     = accept && (mem_req.op == RV_MEM_READ);

  // Read data is taken from state before the accepting edge; RO slots pass hw_in straight through.
  always_comb begin
    rdata = '0;
    if (in_range) begin
      if (RO_MASK[idx]) rdata = hw_in[32'(idx)*DATA_WIDTH +: DATA_WIDTH];
      else              rdata = regs_q[idx];
    end
  end

  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (accept && mem_req.op == RV_MEM_WRITE && in_range) begin
      wr_pulse_d[idx] = 1'b1;
      if (!RO_MASK[idx]) regs_d[idx] = mem_req.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
  end
  assign wr_pulse = wr_pulse_q;

  rv_mem_resp_buffer #(
    .WIDTH(ADDR_WIDTH + DATA_WIDTH)
  ) u_resp_buf (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .push_dat_i({mem_req.addr, rdata}),
    .pop_i     (mem_resp.ready),
    .head_dat_o({mem_resp.addr, mem_resp.data}),
    .full_o    (buf_full),
    .empty_o   (buf_empty)
  );

  assign mem_req.ready  = !buf_full;
  assign mem_resp.valid = !buf_empty;
  assign mem_resp.op    = RV_MEM_READ;

endmodule
